fetch_sequencer: RTL and testbench

Instruction fetch and sequencing stage that sits directly upstream of the instruction decoder. Holds a small writable program memory, a program counter and an instruction register. Runs a 4-phase FETCH/DECODE/EXEC/ADVANCE cycle per instruction. Presents the 4-bit opcode to the decoder and implements the skip-next-instruction behaviour of the SNZA/SNZS opcodes using a condition flag fed back from the datapath.

---
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: program memory, pc, ir and the
// 4-phase FETCH/DECODE/EXEC/ADVANCE cycle with SNZA/SNZS skip support.
//
// Ports:
//   CLKin      system clock (posedge)
//   reset      synchronous active-low reset
//   run        level, continuous execution
//   step       pulse, single instruction from IDLE
//   prog_we    program write enable (IDLE only)
//   prog_addr  program write address
//   prog_data  program word {opcode, operand}
//   skip_cond  datapath flag, sampled in ADVANCE
//   opcode     ir[7:4] to decoder
//   operand    ir[3:0]
//   exec_en    high for the single EXEC cycle
//   pc         program counter
//   phase      0 FETCH/IDLE, 1 DECODE, 2 EXEC, 3 ADVANCE
//   busy       state != IDLE
module fetch_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              CLKin,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              skip_cond,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        phase,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ADV
    } state_t;

    state_t            state;
    state_t            nstate;
    logic [7:0]        ir;
    logic              ss;
    logic              skip;
    logic [ADDR_W-1:0] pc_nx;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    assign opcode  = ir[7:4];
    assign operand = ir[3:0];
    assign busy    = (state != S_IDLE);

    // SNZA (8) / SNZS (9) skip the following word when the flag is set
    assign skip  = ((ir[7:4] == 4'd8) || (ir[7:4] == 4'd9)) && skip_cond;
    assign pc_nx = pc + ADDR_W'(1) + ADDR_W'(skip);

    always_comb begin
        nstate = state;
        phase  = 2'd0;
        unique case (state)
            S_IDLE: begin
                if (run || step) nstate = S_FETCH;
            end
            S_FETCH: begin
                nstate = S_DECODE;
            end
            S_DECODE: begin
                nstate = S_EXEC;
                phase  = 2'd1;
            end
            S_EXEC: begin
                nstate = S_ADV;
                phase  = 2'd2;
            end
            S_ADV: begin
                nstate = (run && !ss) ? S_FETCH : S_IDLE;
                phase  = 2'd3;
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKin) begin
        if (!reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= 8'h00;
            ss      <= 1'b0;
            exec_en <= 1'b0;
        end else begin
            state   <= nstate;
            exec_en <= (nstate == S_EXEC);
            if (state == S_IDLE && (run || step))
                ss <= !run && step;
            if (state == S_FETCH)
                ir <= mem[pc];
            if (state == S_ADV) begin
                pc <= pc_nx;
                if (nstate == S_IDLE) ss <= 1'b0;
            end
        end
    end

    // Memory is deliberately outside reset so programs survive it
    always_ff @(posedge CLKin) begin
        if (reset && prog_we && state == S_IDLE)
            mem[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus
// hand-written multi-cycle sequences, exec results via scoreboard.
module tb_fetch_sequencer;

    logic       CLKin = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       skip_cond = 1'b0;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       exec_en;
    logic [3:0] pc;
    logic [1:0] phase;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int execs = 0;

    typedef struct {
        logic [3:0] op;
        logic [3:0] opr;
        logic [3:0] pc;
    } exp_t;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] word;
        logic       sc;
        logic [3:0] pc_next;
    } vec_t;

    exp_t sb[$];

    fetch_sequencer #(.ADDR_W(4)) dut (
        .CLKin(CLKin),
        .reset(reset),
        .run(run),
        .step(step),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .skip_cond(skip_cond),
        .opcode(opcode),
        .operand(operand),
        .exec_en(exec_en),
        .pc(pc),
        .phase(phase),
        .busy(busy)
    );

    always #5 CLKin = ~CLKin;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKin);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        if (busy) chk(nm, 1, 0);
    endtask

    function automatic exp_t mk(input logic [7:0] w, input logic [3:0] p);
        exp_t e;
        e.op  = w[7:4];
        e.opr = w[3:0];
        e.pc  = p;
        return e;
    endfunction

    // Scoreboard: every exec_en cycle must match the oldest expectation
    always @(negedge CLKin) begin
        if (exec_en) begin
            execs++;
            chk("exec_phase", int'(phase), 2);
            if (sb.size() == 0) begin
                chk("unexpected_exec", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("exec_opcode", int'(opcode), int'(e.op));
                chk("exec_operand", int'(operand), int'(e.opr));
                chk("exec_pc", int'(pc), int'(e.pc));
            end
        end
    end

    initial begin
        vec_t       tbl[12];
        logic [7:0] bw[16];
        int         base;

        tbl[0]  = '{4'd0,  8'h15, 1'b1, 4'd1};
        tbl[1]  = '{4'd1,  8'h27, 1'b0, 4'd2};
        tbl[2]  = '{4'd2,  8'h80, 1'b1, 4'd4};
        tbl[3]  = '{4'd4,  8'h80, 1'b0, 4'd5};
        tbl[4]  = '{4'd5,  8'h20, 1'b1, 4'd6};
        tbl[5]  = '{4'd6,  8'h96, 1'b0, 4'd7};
        tbl[6]  = '{4'd7,  8'h91, 1'b1, 4'd9};
        tbl[7]  = '{4'd9,  8'h95, 1'b1, 4'd11};
        tbl[8]  = '{4'd11, 8'h33, 1'b1, 4'd12};
        tbl[9]  = '{4'd12, 8'h44, 1'b0, 4'd13};
        tbl[10] = '{4'd13, 8'h55, 1'b0, 4'd14};
        tbl[11] = '{4'd14, 8'h90, 1'b1, 4'd0};

        for (int i = 0; i < 16; i++)
            bw[i] = {4'(i), 4'(15 - i)};
        bw[0] = 8'h15;
        bw[1] = 8'h27;
        bw[2] = 8'hA0;
        bw[3] = 8'hF3;

        // Reset held with run high
        reset = 1'b0;
        run   = 1'b1;
        tick();
        tick();
        chk("rst_pc", int'(pc), 0);
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_exec_en", int'(exec_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_phase", int'(phase), 0);
        run   = 1'b0;
        reset = 1'b1;
        tick();

        // Continuous run over all 16 words, wrapping 15 -> 0
        for (int i = 0; i < 16; i++) wr(4'(i), bw[i]);
        skip_cond = 1'b0;
        for (int i = 0; i < 16; i++) sb.push_back(mk(bw[i], 4'(i)));
        run = 1'b1;
        begin
            int seen = 0;
            int lastc = -1;
            int cyc = 0;
            while (seen < 16 && cyc < 200) begin
                tick();
                cyc++;
                if (exec_en) begin
                    seen++;
                    if (lastc >= 0) chk("exec_spacing", cyc - lastc, 4);
                    if (seen == 1) chk("first_exec_lat", cyc, 3);
                    lastc = cyc;
                    if (seen == 16) run = 1'b0;
                end
            end
            if (seen < 16) chk("run_timeout", seen, 16);
        end
        run = 1'b0;
        wait_idle("run_idle_timeout");
        chk("run_wrap_pc", int'(pc), 0);
        chk("run_busy", int'(busy), 0);

        // Reset again; mem[0..1] are not rewritten, so row 0/1 prove retention
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 2; i < 16; i++) wr(4'(i), 8'hEE);
        wr(4'd3, 8'hF3);
        for (int i = 2; i < 12; i++) wr(tbl[i].pc, tbl[i].word);

        // Table: one single step per record
        for (int i = 0; i < 12; i++) begin
            skip_cond = tbl[i].sc;
            sb.push_back(mk(tbl[i].word, tbl[i].pc));
            base = execs;
            step = 1'b1;
            tick();
            step = 1'b0;
            wait_idle("step_timeout");
            tick();
            chk($sformatf("tbl%0d_pc", i), int'(pc), int'(tbl[i].pc_next));
            chk($sformatf("tbl%0d_execs", i), execs - base, 1);
        end
        skip_cond = 1'b0;

        // Step held high while busy must not start a second instruction
        sb.push_back(mk(8'h15, 4'd0));
        base = execs;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        wait_idle("sb_timeout");
        tick();
        chk("stepbusy_execs", execs - base, 1);
        chk("stepbusy_pc", int'(pc), 1);

        // Run dropped during DECODE still completes the instruction
        sb.push_back(mk(8'h27, 4'd1));
        base = execs;
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        chk("drop_in_decode", int'(phase), 1);
        wait_idle("drop_timeout");
        tick();
        chk("drop_execs", execs - base, 1);
        chk("drop_pc", int'(pc), 2);

        // Write during EXEC is dropped: pc 3 still fetches the old word
        sb.push_back(mk(8'h80, 4'd2));
        sb.push_back(mk(8'hF3, 4'd3));
        run = 1'b1;
        begin
            int k = 0;
            while (phase != 2'd2 && k < 20) begin
                tick();
                k++;
            end
            chk("we_exec_phase", int'(phase), 2);
        end
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = 8'h11;
        tick();
        prog_we = 1'b0;
        begin
            int k = 0;
            while (!exec_en && k < 20) begin
                tick();
                k++;
            end
            chk("we_second_exec", int'(exec_en), 1);
        end
        run = 1'b0;
        wait_idle("we_timeout");
        chk("we_pc", int'(pc), 4);

        // Write in IDLE alongside run: the fetch sees the new word
        sb.push_back(mk(8'h3C, 4'd4));
        prog_we   = 1'b1;
        prog_addr = 4'd4;
        prog_data = 8'h3C;
        run       = 1'b1;
        tick();
        prog_we = 1'b0;
        begin
            int k = 0;
            while (!exec_en && k < 20) begin
                tick();
                k++;
            end
            chk("wrun_exec", int'(exec_en), 1);
        end
        run = 1'b0;
        wait_idle("wrun_timeout");
        chk("wrun_pc", int'(pc), 5);

        // Reset during DECODE abandons the instruction
        tick();
        base = execs;
        run  = 1'b1;
        tick();
        tick();
        chk("rmid_phase", int'(phase), 1);
        reset = 1'b0;
        tick();
        run = 1'b0;
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_pc", int'(pc), 0);
        chk("rmid_exec_en", int'(exec_en), 0);
        chk("rmid_phase0", int'(phase), 0);
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("rmid_no_exec", execs - base, 0);
        chk("rmid_idle", int'(busy), 0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1);
    end

endmodule
